serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an addition, sampled on each rising edge.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, captured when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, captured when start is accepted.
REQ-007 The block SHALL have port busy  output  1  high while an addition is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse marking that sum/co are valid.
REQ-009 The block SHALL have port sum  output  WIDTH  result bits of a+b.
REQ-010 The block SHALL have port co  output  1  carry out of bit WIDTH-1.

Function
REQ-011 The block SHALL sequence one shared 1-bit full-adder datapath over WIDTH cycles, LSB first; there SHALL be no WIDTH-bit parallel adder.
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a and b, clear the carry register and bit counter, and go to RUN at that edge.
REQ-014 In RUN, each edge SHALL add operand bit i, operand bit i and the carry register, write sum[i], update the carry, and increment i.
REQ-015 When i = WIDTH-1 is processed, the block SHALL load co with the final carry and go to DONE.
REQ-016 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE unconditionally.
REQ-017 Latency SHALL be fixed: done SHALL be high in the cycle following the WIDTH-th edge after the edge that accepted start.
REQ-018 busy SHALL equal 1 exactly in RUN; done SHALL equal 1 exactly in DONE.
REQ-019 start SHALL be ignored in RUN and DONE; the earliest next acceptance is the first IDLE cycle after DONE.
REQ-020 Changes on a and b after acceptance SHALL NOT affect the result.
REQ-021 sum and co SHALL hold their last values in IDLE until the next accepted start; partial sum bits MAY be visible during RUN.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH, with co holding bit WIDTH.

Reset
REQ-023 With rst=1 at an edge, the state SHALL go to IDLE, and busy=0, done=0, sum=0, co=0, with the counter and carry cleared.
REQ-024 rst SHALL take priority over start and over any in-flight operation; an aborted addition SHALL produce no done pulse.
REQ-025 start present in the same cycle as rst SHALL be discarded.

Configuration
REQ-026 When macro SERIAL_ADD_CTRL_OVF_EN is defined, the block SHALL add port ovf  output  1  signed two's-complement overflow flag.
REQ-027 With the macro defined, ovf SHALL be set at entry to DONE to (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), held like co, and reset to 0.
REQ-028 Without the macro, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 A shared package serial_add_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default constant.
REQ-030 The per-bit datapath SHALL be a sub-module full_add (ports a, b, ci, co, s) built from two half adders plus an OR gate; serial_add_ctrl SHALL instantiate exactly one.

Verification
REQ-031 WIDTH=8, a=0x00, b=0x00, one start pulse -> done after 8 edges, sum=0x00, co=0, busy high for 8 cycles.
REQ-032 a=0xFF, b=0x01 -> sum=0x00, co=1; with the macro, ovf=0.
REQ-033 a=0x7F, b=0x01 with the macro -> sum=0x80, co=0, ovf=1.
REQ-034 a=0x35, b=0x0A accepted; start held high with a=0xFF during RUN -> result 0x3F, co=0, a single done pulse; the next acceptance is in the IDLE cycle after DONE.
REQ-035 rst asserted on the 4th RUN cycle -> next cycle IDLE, sum=0x00, co=0, no done; a following start with a=0x10, b=0x20 -> sum=0x30.
REQ-036 Back-to-back operations (start held high continuously) -> done every WIDTH+2 cycles, each result correct.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
// No ports; imported by serial_add_ctrl.
package serial_add_pkg;

  // Default operand width; legal range is 2..32.
  localparam int WIDTH_DEF = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_full_add.sv
// full_add: 1-bit full adder made from two half adders and an OR gate.
// Latency: purely combinational. Backpressure: none.
// Ports: a, b, ci (inputs); s = a^b^ci, co = carry out.
module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  // First half adder: a + b.
  assign w_s1 = a ^ b;
  assign w_c1 = a & b;

  // Second half adder: partial sum + carry in.
  assign s    = w_s1 ^ ci;
  assign w_c2 = w_s1 & ci;

  // The two half-adder carries can never both be 1, so OR merges them.
  assign co   = w_c1 | w_c2;

endmodule : full_add

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial unsigned adder, one shared full adder, LSB first.
// Latency: done pulses in the cycle after the WIDTH-th edge after the accepting edge.
// Backpressure: start is ignored while busy or done; next accept is the first IDLE cycle.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done, sum, co.
// Optional: define SERIAL_ADD_CTRL_OVF_EN to add output ovf (signed overflow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADD_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_co;

  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  assign w_bit_a = r_a[r_cnt];
  assign w_bit_b = r_b[r_cnt];
  assign w_last  = (r_cnt == LAST);

  // The single datapath adder, reused once per bit position.
  full_add u_full_add (
    .a  (w_bit_a),
    .b  (w_bit_b),
    .ci (r_carry),
    .co (w_c),
    .s  (w_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and status decode.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Operand capture and per-bit accumulation. Reset wins over start and
  // over an in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum[r_cnt] <= w_s;
          r_carry      <= w_c;
          r_cnt        <= r_cnt + CW'(1);
          if (w_last) begin
            r_co <= w_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic r_ovf;

  // At the MSB, r_carry is the carry into bit WIDTH-1 and w_c the carry out;
  // they differ exactly when the signed result overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= r_carry ^ w_c;
    end
  end

  assign ovf = r_ovf;
`endif

  assign sum = r_sum;
  assign co  = r_co;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         co;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_done_cyc = -1;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; signed overflow from operand/result signs.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = ref_add(x, y);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // One operation from an IDLE cycle. mode: 0 keep inputs, 1 randomize a/b
  // during RUN, 2 force a to all-ones during RUN. hold keeps start high.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input bit hold, input int mode, input bit chk_period);
    logic [W:0] exp;
    int         n_busy;
    int         done_at;
    exp     = ref_add(ta, tb_v);
    start   = 1'b1;
    a       = ta;
    b       = tb_v;
    tick();
    if (!hold) start = 1'b0;
    n_busy  = 0;
    done_at = -1;
    for (int k = 0; k <= W + 3; k++) begin
      if (done) begin
        done_at = k;
        break;
      end
      if (busy) n_busy++;
      if (mode == 1) begin
        a = W'($urandom);
        b = W'($urandom);
      end else if (mode == 2) begin
        a = '1;
      end
      tick();
    end
    chk({tag, ".done_latency"}, done_at, W);
    chk({tag, ".busy_cycles"}, n_busy, W);
    chk({tag, ".sum"}, sum, exp[W-1:0]);
    chk({tag, ".co"}, co, exp[W]);
    chk({tag, ".busy_in_done"}, busy, 0);
`ifdef SERIAL_ADD_CTRL_OVF_EN
    chk({tag, ".ovf"}, ovf, ref_ovf(ta, tb_v));
`endif
    if (chk_period && last_done_cyc >= 0) chk({tag, ".period"}, cyc - last_done_cyc, W + 2);
    last_done_cyc = cyc;
    tick();
    chk({tag, ".idle_done"}, done, 0);
    chk({tag, ".idle_busy"}, busy, 0);
    chk({tag, ".idle_sum_hold"}, sum, exp[W-1:0]);
    chk({tag, ".idle_co_hold"}, co, exp[W]);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    tick();
    tick();
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.sum", sum, 0);
    chk("reset.co", co, 0);
`ifdef SERIAL_ADD_CTRL_OVF_EN
    chk("reset.ovf", ovf, 0);
`endif
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("post_reset.busy", busy, 0);

    do_op("zero", 8'h00, 8'h00, 1'b0, 0, 1'b0);
    do_op("ff_plus_1", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op("7f_plus_1", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
    do_op("80_plus_80", 8'h80, 8'h80, 1'b0, 0, 1'b0);

    // start held with a changed to all-ones during the run.
    do_op("held_start", 8'h35, 8'h0A, 1'b1, 2, 1'b0);
    // Still held: acceptance happens at the very next edge from IDLE.
    do_op("held_next", 8'h01, 8'h02, 1'b0, 0, 1'b1);

    // Abort on the 4th RUN cycle.
    start = 1'b1;
    a     = 8'hF0;
    b     = 8'h0F;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("abort.busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.sum", sum, 0);
    chk("abort.co", co, 0);
    begin
      int n_done;
      n_done = 0;
      for (int k = 0; k < W + 3; k++) begin
        tick();
        if (done || busy) n_done++;
      end
      chk("abort.no_done", n_done, 0);
    end

    // start coinciding with reset is dropped.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_start.busy", busy, 0);
    do_op("after_abort", 8'h10, 8'h20, 1'b0, 0, 1'b0);

    // Back-to-back with start continuously high, random operands.
    last_done_cyc = -1;
    for (int n = 0; n < 6; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op("b2b", ra, rb, 1'b1, 1, 1'b1);
    end
    start = 1'b0;
    tick();

    // Random isolated operations with input churn during RUN.
    for (int n = 0; n < 12; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op("rand", ra, rb, 1'b0, 1, 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_add_ctrl
